// File: rtl/pc_next_unit_pkg.sv
// Shared constants and state encoding for the program-counter stage.
package pc_next_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXC   = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;

endpackage

// File: rtl/pc_next_unit_next_pc_mux.sv
// Next-PC source selection: priority jr > jump > branch > sequential,
// plus misalignment detection on the data-dependent targets.
module next_pc_mux
    import pc_next_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        branch_taken_i,
    input  logic [31:0] br_offset_sh_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic check_align;

    assign pc_plus4_o = pc_i + PC_STEP;

    always_comb begin
        target_o    = pc_plus4_o;
        check_align = 1'b0;
        if (jr_i) begin
            target_o    = jr_target_i;
            check_align = 1'b1;
        end else if (jump_i) begin
            target_o = {pc_plus4_o[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            target_o    = pc_plus4_o + br_offset_sh_i;
            check_align = 1'b1;
        end
    end

    // Jump and sequential targets are word-aligned by construction.
    assign misalign_o = check_align & (|target_o[1:0]);

endmodule

// File: rtl/pc_next_unit.sv
// PC register and fetch-control FSM; traps misaligned redirects to EXC_VECTOR
// and holds fetch until software acknowledges with exc_clear.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] br_offset_sh,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        if_ready,
    input  logic        exc_clear,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_req,
    output logic        misalign_exc,
    output logic [31:0] bad_addr
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic        exc_q, exc_d;
    logic [31:0] target;
    logic        misalign;
    logic        advance;

    next_pc_mux u_mux (
        .pc_i           (pc_q),
        .jr_i           (jr),
        .jr_target_i    (jr_target),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .branch_taken_i (branch_taken),
        .br_offset_sh_i (br_offset_sh),
        .pc_plus4_o     (pc_plus4),
        .target_o       (target),
        .misalign_o     (misalign)
    );

    assign advance = (state_q == FETCH) && if_ready && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        exc_d   = exc_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (advance) begin
                    if (misalign) begin
                        pc_d    = EXC_VECTOR;
                        bad_d   = target;
                        exc_d   = 1'b1;
                        state_d = EXC;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            EXC: begin
                // pc already sits at EXC_VECTOR, so fetch resumes there.
                if (exc_clear) begin
                    exc_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            bad_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            exc_q   <= exc_d;
        end
    end

    assign pc           = pc_q;
    assign if_req       = (state_q == FETCH);
    assign misalign_exc = exc_q;
    assign bad_addr     = bad_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed and randomized checks of pc_next_unit against a behavioural model.
module tb_pc_next_unit;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_EXC_VEC  = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, jr, if_ready, exc_clear;
    logic [31:0] br_offset_sh, jr_target;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, bad_addr;
    logic        if_req, misalign_exc;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_pc, m_bad;
    bit          m_boot, m_exc;

    pc_next_unit #(.RESET_PC(T_RESET_PC), .EXC_VECTOR(T_EXC_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .br_offset_sh(br_offset_sh), .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_target(jr_target), .if_ready(if_ready), .exc_clear(exc_clear),
        .pc(pc), .pc_plus4(pc_plus4), .if_req(if_req),
        .misalign_exc(misalign_exc), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},       pc,                    m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4,              m_pc + 32'd4);
        chk({tag, ".if_req"},   {31'd0, if_req},       {31'd0, !m_boot && !m_exc});
        chk({tag, ".misalign"}, {31'd0, misalign_exc}, {31'd0, m_exc});
        chk({tag, ".bad_addr"}, bad_addr,              m_bad);
    endtask

    task automatic model_reset();
        m_pc = T_RESET_PC; m_bad = '0; m_boot = 1; m_exc = 0;
    endtask

    // One clock edge: the model applies the rules to the inputs in effect now.
    task automatic step(input string tag);
        logic [31:0] nxt, tgt;
        bit          aligned_chk;
        nxt = m_pc + 32'd4;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_exc) begin
            if (exc_clear) m_exc = 0;
        end else if (if_ready && !stall) begin
            aligned_chk = 1;
            if (jr)                tgt = jr_target;
            else if (jump)         begin tgt = {nxt[31:28], jump_index, 2'b00}; aligned_chk = 0; end
            else if (branch_taken) tgt = nxt + br_offset_sh;
            else                   begin tgt = nxt; aligned_chk = 0; end
            if (aligned_chk && (tgt % 4 != 0)) begin
                m_exc = 1; m_bad = tgt; m_pc = T_EXC_VEC;
            end else begin
                m_pc = tgt;
            end
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; br_offset_sh = '0; jump = 0; jump_index = '0;
        jr = 0; jr_target = '0; if_ready = 1; exc_clear = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset");
        rst_n = 1;
        #1 chk_all("boot_cycle");
        step("first_fetch");
        step("seq4");
        step("seq8");
        step("seq12");

        // Branch backwards from 0x100
        jr = 1; jr_target = 32'h0000_0100; step("jr_0x100");
        jr = 0; branch_taken = 1; br_offset_sh = 32'hFFFF_FFF0; step("branch_neg");
        chk("branch_abs", pc, 32'h0000_00F4);
        stall = 1; step("stall1"); step("stall2");
        chk("stall_hold", pc, 32'h0000_00F4);
        stall = 0; branch_taken = 0;

        // Jump beats branch
        jr = 1; jr_target = 32'h4000_0010; step("jr_0x40000010");
        jr = 0; jump = 1; jump_index = 26'h000_0040; branch_taken = 1; step("jump_vs_branch");
        chk("jump_abs", pc, 32'h4000_0100);
        jump = 0; branch_taken = 0;

        // Misaligned JR trap and clear
        jr = 1; jr_target = 32'h0000_2002; step("jr_misalign");
        chk("trap_bad", bad_addr, 32'h0000_2002);
        jr = 0; stall = 1; step("exc_hold_stall");
        stall = 0; exc_clear = 1; step("exc_clear");
        exc_clear = 0; step("resume_at_vec");

        // Wrap with backpressure
        jr = 1; jr_target = 32'hFFFF_FFFC; step("jr_top");
        jr = 0; if_ready = 0; step("bp1"); step("bp2");
        if_ready = 1; step("wrap");
        chk("wrap_abs", pc, 32'h0000_0000);

        // Async reset mid-EXC, between edges
        jr = 1; jr_target = 32'h0000_0301; step("enter_exc");
        jr = 0;
        #3 rst_n = 0;
        model_reset();
        #1 chk_all("async_reset");
        #2 rst_n = 1;
        step("post_reset_boot");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            stall        = ($urandom_range(0, 3) == 0);
            if_ready     = ($urandom_range(0, 3) != 0);
            jr           = ($urandom_range(0, 7) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            exc_clear    = ($urandom_range(0, 2) == 0);
            jump_index   = 26'($urandom);
            jr_target    = $urandom;
            if ($urandom_range(0, 2) != 0) jr_target[1:0] = 2'b00;
            br_offset_sh = {{14{1'b0}}, 18'($urandom)} << 2;
            if ($urandom_range(0, 1) == 1) br_offset_sh = -br_offset_sh;
            if ($urandom_range(0, 9) == 0) br_offset_sh[1:0] = 2'($urandom_range(1, 3));
            step($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
